count_sequence_monitor: RTL and testbench
=========================================

# count_sequence_monitor

Passive checker that sits beside a self-correcting up-counter and watches its `count` bus and `enable` input. It confirms that every step is legal: hold when disabled, +1 with wrap at `MAX_COUNT` when enabled. It flags out-of-range values and bad transitions, keeps a saturating error tally, and reports a `locked` status once it has seen a run of consecutive legal transitions. It is the receive-side counterpart of the counter and has no influence on the counter itself.

## Interface
- `WIDTH`, default 4: width of the observed count bus.
- `MAX_COUNT`, default 15: terminal value; the legal range is 0..MAX_COUNT, and the value after MAX_COUNT is 0. Must satisfy MAX_COUNT ≤ 2^WIDTH−1.
- `RELOCK_LEN`, default 4: number of consecutive legal transitions required to enter LOCKED, range 1..255.
- `ERR_W`, default 8: width of the error counter.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `enable`, input, 1: the enable seen by the monitored counter, in the same cycle.
- `count_in`, input, WIDTH: the monitored counter's output.
- `clear_err`, input, 1: synchronous clear of `err_count`.
- `locked`, output, 1: high while the FSM is in LOCKED.
- `err_pulse`, output, 1: one-cycle pulse for each mismatch detected in LOCKED.
- `illegal`, output, 1: registered flag, high for one cycle after a sample with count_in > MAX_COUNT.
- `err_count`, output, ERR_W: saturating count of LOCKED-state mismatches.
- `expected`, output, WIDTH: value the monitor predicts for the next `count_in` sample.

## Operation
- **Registered history.** `prev_cnt` and `prev_en` hold the previous sample.
- **Prediction.** `pred = prev_en ? (prev_cnt == MAX_COUNT ? 0 : prev_cnt + 1) : prev_cnt`. The increment is WIDTH-bit, and wrap is forced explicitly at MAX_COUNT, not at 2^WIDTH.
- **Mismatch.** A sample is a mismatch when count_in ≠ pred, or when count_in > MAX_COUNT.
- **FSM states: IDLE, ACQUIRE, LOCKED.**
  - IDLE: the first sample after reset loads the history, with no comparison. Go to ACQUIRE with run = 0.
  - ACQUIRE: a legal sample increments run. When run reaches RELOCK_LEN, go to LOCKED. A mismatch sets run = 0 and stays in ACQUIRE. No err_pulse is raised and err_count does not change.
  - LOCKED: a mismatch raises err_pulse, increments err_count, and moves to ACQUIRE with run = 0.
- **History after a mismatch.** The history always reloads from the actual count_in, so the monitor re-synchronises on the counter's corrected value.
- **Illegal samples.** `illegal` is asserted for any out-of-range sample in ACQUIRE or LOCKED, independent of the other checks.
- **Error counter.** err_count saturates at 2^ERR_W−1 and never wraps.
- **Clear collision.** If clear_err and an increment occur in the same cycle, err_count becomes 1.
- **Expected output.** `expected` presents pred registered for the next cycle, computed from the current sample and enable.

## Timing
- **Reset values.** On reset: state IDLE, locked 0, err_pulse 0, illegal 0, err_count 0, expected 0, prev_cnt 0, prev_en 0, run 0.
- **Reset mid-operation.** Asserting rst_n mid-run returns the monitor to IDLE immediately; no pulse is emitted.
- **Detection latency.** err_pulse and illegal assert in the cycle after the offending sample edge, i.e. one cycle of latency. Each lasts exactly one cycle.
- **Lock latency.** locked rises on the edge that takes in the RELOCK_LEN-th legal sample counted in ACQUIRE. From reset with a clean counter, locked is high RELOCK_LEN+1 edges after rst_n deasserts.
- **Unlock latency.** locked falls on the same edge that raises err_pulse.
- **Back-to-back mismatches.** Only the first mismatch, the one seen in LOCKED, is counted.
- **Disabled counter.** With enable held low, a constant count_in is legal indefinitely.

## Structure
- **Package `count_mon_pkg`.** Holds the FSM state enum (`mon_state_t`: IDLE, ACQUIRE, LOCKED) and the function `next_count(cnt, en, max)`, shared with the counter's bench model.
- **Sub-module `sat_counter`.** Parameterised width, with `inc`, `clr` (clr-then-inc priority) and a saturating output. It implements err_count; the run counter stays inline.

## Test plan
- **Clean lock.** Reset, then enable=1 with count 0,1,2,…. Expect locked=1 after RELOCK_LEN+1 edges, err_count=0, and `expected` tracking count+1.
- **Wrap.** In LOCKED with MAX_COUNT=9, drive 8,9,0,1. Expect no err_pulse. Then drive 9→10 (WIDTH=4). Expect illegal=1, err_pulse=1, err_count=1, locked=0.
- **Hold.** In LOCKED with count=5, drive enable=0 with count 5,5,5. Expect no error. Then drive 5→6 while enable=0. Expect err_pulse and err_count+1.
- **Relock and isolation.** After one error, inject a second skip during ACQUIRE. Expect err_count unchanged and no pulse. After RELOCK_LEN clean steps, expect locked=1.
- **Saturation and clear.** With ERR_W=2, force 5 errors. Expect err_count held at 3. Then assert clear_err together with a sixth error. Expect err_count=1.
- **Async reset.** Assert rst_n mid-LOCKED between clock edges. Expect all outputs at 0 immediately, then IDLE behaviour on release.

Source files
------------

// File: rtl/count_sequence_monitor_pkg.sv
// Shared types and the reference step function for the monitored up-counter.
// The counter's bench model uses next_count as well.
package count_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    // Callers truncate to their bus width, so the +1 behaves as a WIDTH-bit increment.
    function automatic logic [31:0] next_count(input logic [31:0] cnt,
                                               input logic        en,
                                               input logic [31:0] max);
        if (!en)
            return cnt;
        if (cnt == max)
            return 32'd0;
        return cnt + 32'd1;
    endfunction

endpackage

// File: rtl/count_sequence_monitor_if.sv
// Observation bus between the monitored counter and the sequence monitor.
interface count_sequence_monitor_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             enable;
    logic [WIDTH-1:0] count_in;
    logic             clear_err;
    logic             locked;
    logic             err_pulse;
    logic             illegal;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output enable, count_in, clear_err,
        input  locked, err_pulse, illegal, err_count, expected
    );

    modport slave (
        input  enable, count_in, clear_err,
        output locked, err_pulse, illegal, err_count, expected
    );
endinterface

// File: rtl/count_sequence_monitor_sat_counter.sv
// Saturating event counter; a clear in the same cycle as an event leaves one count.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] SAT = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= inc ? W'(1) : '0;
        else if (inc && cnt != SAT)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/count_sequence_monitor.sv
// Passive checker for a wrapping up-counter: predicts each sample from the previous one,
// locks after a run of legal steps and tallies mismatches seen while locked.
module count_sequence_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MAX_COUNT  = 15,
    parameter int RELOCK_LEN = 4,
    parameter int ERR_W      = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    count_sequence_monitor_if.slave bus
);
    // One extra bit keeps the range test meaningful when MAX_COUNT fills the bus.
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_COUNT);
    localparam logic [7:0]     RUN_TGT = 8'(RELOCK_LEN);

    mon_state_t       state_q, state_d;
    logic [7:0]       run_q, run_d;
    logic [WIDTH-1:0] prev_cnt;
    logic             prev_en;
    logic [WIDTH-1:0] pred;
    logic             out_range;
    logic             mismatch;
    logic             pulse_d, pulse_q;
    logic             illegal_d, illegal_q;
    logic             err_inc;

    assign pred      = WIDTH'(next_count(32'(prev_cnt), prev_en, 32'(MAX_COUNT)));
    assign out_range = {1'b0, bus.count_in} > MAX_EXT;
    assign mismatch  = (bus.count_in != pred) || out_range;

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        pulse_d   = 1'b0;
        illegal_d = 1'b0;
        err_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = ACQUIRE;
                run_d   = '0;
            end
            ACQUIRE: begin
                illegal_d = out_range;
                if (mismatch) begin
                    run_d = '0;
                end else if (run_q + 8'd1 == RUN_TGT) begin
                    state_d = LOCKED;
                    run_d   = '0;
                end else begin
                    run_d = run_q + 8'd1;
                end
            end
            LOCKED: begin
                illegal_d = out_range;
                if (mismatch) begin
                    pulse_d = 1'b1;
                    err_inc = 1'b1;
                    state_d = ACQUIRE;
                    run_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // History always follows the real counter so a corrected value resynchronises us.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            run_q     <= '0;
            prev_cnt  <= '0;
            prev_en   <= 1'b0;
            pulse_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            prev_cnt  <= bus.count_in;
            prev_en   <= bus.enable;
            pulse_q   <= pulse_d;
            illegal_q <= illegal_d;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err_inc),
        .clr  (bus.clear_err),
        .cnt  (bus.err_count)
    );

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = pulse_q;
    assign bus.illegal   = illegal_q;
    assign bus.expected  = pred;
endmodule

// File: tb/tb_count_sequence_monitor.sv
// Directed bench: each driven sample pushes its expected outputs, which are popped and
// compared one edge later.
module tb_count_sequence_monitor;
    localparam int WIDTH      = 4;
    localparam int MAX_COUNT  = 9;
    localparam int RELOCK_LEN = 4;
    localparam int ERR_W      = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    count_sequence_monitor_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

    count_sequence_monitor #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .RELOCK_LEN(RELOCK_LEN),
        .ERR_W     (ERR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic             locked;
        logic             pulse;
        logic             illegal;
        logic [ERR_W-1:0] err;
        logic [WIDTH-1:0] exp;
        int               id;
    } exp_t;

    exp_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   step_no = 0;

    function automatic int nx(input int v);
        return (v == MAX_COUNT) ? 0 : v + 1;
    endfunction

    task automatic check(input string tag, input int id, input logic [7:0] obs, input logic [7:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s step %0d: observed=%0d expected=%0d", tag, id, obs, req);
        end
    endtask

    task automatic compare();
        exp_t e;
        e = sb.pop_front();
        check("locked",    e.id, 8'(bus.locked),    8'(e.locked));
        check("err_pulse", e.id, 8'(bus.err_pulse), 8'(e.pulse));
        check("illegal",   e.id, 8'(bus.illegal),   8'(e.illegal));
        check("err_count", e.id, 8'(bus.err_count), 8'(e.err));
        check("expected",  e.id, 8'(bus.expected),  8'(e.exp));
    endtask

    task automatic step(input int cnt, input logic en, input logic clr,
                        input logic lk, input logic pl, input logic il, input int er, input int ex);
        exp_t e;
        bus.count_in  = WIDTH'(cnt);
        bus.enable    = en;
        bus.clear_err = clr;
        step_no++;
        e.locked  = lk;
        e.pulse   = pl;
        e.illegal = il;
        e.err     = ERR_W'(er);
        e.exp     = WIDTH'(ex);
        e.id      = step_no;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    // RELOCK_LEN clean enabled samples from ACQUIRE with run at zero.
    task automatic relock(input int start, input int er);
        for (int i = 0; i < RELOCK_LEN; i++) begin
            int v;
            v = (start + i) % (MAX_COUNT + 1);
            step(v, 1'b1, 1'b0, i == RELOCK_LEN - 1, 1'b0, 1'b0, er, nx(v));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"},  0, 8'(bus.locked),    8'd0);
        check({tag, "_pulse"},   0, 8'(bus.err_pulse), 8'd0);
        check({tag, "_illegal"}, 0, 8'(bus.illegal),   8'd0);
        check({tag, "_err"},     0, 8'(bus.err_count), 8'd0);
        check({tag, "_exp"},     0, 8'(bus.expected),  8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.enable    = 1'b0;
        bus.count_in  = '0;
        bus.clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Clean lock from reset, then run through the wrap 8,9,0,1 while locked.
        for (int k = 0; k <= 12; k++)
            step(k % 10, 1'b1, 1'b0, k >= RELOCK_LEN, 1'b0, 1'b0, 0, nx(k % 10));
        for (int k = 3; k <= 9; k++)
            step(k, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, nx(k));

        // 9 -> 10: out of range and a mismatch while locked.
        step(10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 11);
        // Corrected value is a second mismatch, seen in ACQUIRE: not counted.
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
        relock(1, 1);

        // Hold with enable low, then a step while disabled.
        for (int k = 0; k < 3; k++)
            step(5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 5);
        step(6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 6);

        // Skip injected during ACQUIRE leaves the tally alone.
        step(6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 7);
        step(7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 8);
        step(9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
        relock(0, 2);

        // Errors 3..5 with a 2-bit tally: saturates at 3.
        step(5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 6);
        relock(6, 3);
        step(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 3);
        relock(3, 3);
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1);
        relock(1, 3);
        // Clear together with a sixth error.
        step(7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 8);
        relock(8, 1);

        // Asynchronous reset between edges while locked.
        #3 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First sample after reset only loads history, even when out of range.
        step(12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 12);
        // Out-of-range in ACQUIRE: illegal, but no pulse or count.
        step(12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 12);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
